fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN sequencer.
// Optional stall-cycle counter port is built only when FETCH_STALLCNT_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset: PC held, IF/ID stays invalid
// RUN   | normal fetch: redirect flushes, stall holds, otherwise fetch and advance
module fetch_stage #(
    parameter int               DBITS    = 32,
    parameter int               ADDRBITS = 13,
    parameter logic [DBITS-1:0] STARTPC  = 'h40,
    parameter logic [DBITS-1:0] NOP      = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [DBITS-1:0]    redirect_pc,
    output logic [ADDRBITS-1:0] imem_addr,
    input  logic [DBITS-1:0]    imem_instr,
    output logic [DBITS-1:0]    ifid_instr,
    output logic [DBITS-1:0]    ifid_pc,
    output logic [DBITS-1:0]    ifid_pcplus,
    output logic                ifid_valid
`ifdef FETCH_STALLCNT_EN
    ,
    output logic [31:0]         stallcnt
`endif
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t           state, state_next;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pc_plus4;
    logic [DBITS-1:0] redirect_aligned;
    logic             do_fetch;
    logic             do_flush;

    assign pc_plus4         = pc + DBITS'(4);
    assign redirect_aligned = redirect_pc & ~DBITS'(3);
    assign imem_addr        = pc[ADDRBITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_fetch   = 1'b0;
        do_flush   = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    do_flush = 1'b1;
                end else if (!stall) begin
                    do_fetch = 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // A flush leaves IFID_PC/IFID_PCPLUS alone; IFID_VALID=0 marks them stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= STARTPC;
            ifid_instr  <= NOP;
            ifid_pc     <= '0;
            ifid_pcplus <= '0;
            ifid_valid  <= 1'b0;
        end else if (do_flush) begin
            pc          <= redirect_aligned;
            ifid_instr  <= NOP;
            ifid_valid  <= 1'b0;
        end else if (do_fetch) begin
            pc          <= pc_plus4;
            ifid_instr  <= imem_instr;
            ifid_pc     <= pc;
            ifid_pcplus <= pc_plus4;
            ifid_valid  <= 1'b1;
        end
    end

`ifdef FETCH_STALLCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcnt <= '0;
        end else if ((state == RUN) && stall && !redirect && (stallcnt != 32'hFFFF_FFFF)) begin
            stallcnt <= stallcnt + 32'd1;
        end
    end
`endif

endmodule
